// File: rtl/fft_source_capture_if.sv
// Avalon-ST source link from the FFT core.
// master = FFT core side, slave = capture side.
interface fft_source_capture_if #(
  parameter int DATA_W = 16
);
  logic                     source_valid;
  logic                     source_ready;
  logic                     source_sop;
  logic                     source_eop;
  logic [1:0]               source_error;
  logic signed [DATA_W-1:0] source_real;
  logic signed [DATA_W-1:0] source_imag;
  logic [5:0]               source_exp;

  modport master (
    output source_valid,
    output source_sop,
    output source_eop,
    output source_error,
    output source_real,
    output source_imag,
    output source_exp,
    input  source_ready
  );

  modport slave (
    input  source_valid,
    input  source_sop,
    input  source_eop,
    input  source_error,
    input  source_real,
    input  source_imag,
    input  source_exp,
    output source_ready
  );
endinterface

// File: rtl/fft_source_capture.sv
// FFT source-stream capture: framing checks, bin power, frame handoff.
// Optional PEAK_DETECT_EN adds peak_pwr/peak_bin over bins 1..FFT_PTS/2-1.
module fft_source_capture #(
  parameter int FFT_PTS = 1024,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int PWR_W   = 33
) (
  input  logic              clk,
  input  logic              reset_n,
  fft_source_capture_if.slave src,
  input  logic              frame_ack,
  input  logic              err_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PWR_W-1:0]  wr_data,
  output logic              frame_done,
  output logic [5:0]        frame_exp,
  output logic [2:0]        err_flags
`ifdef PEAK_DETECT_EN
  ,
  output logic [PWR_W-1:0]  peak_pwr,
  output logic [ADDR_W-1:0] peak_bin
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FFT_PTS - 1);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cnt, cnt_nxt, bin;
  logic              bad, bad_nxt, bad_now;
  logic              acc, beat, last_good;
  logic              src_err;
  logic [2:0]        err_set;

  logic signed [2*DATA_W-1:0] re_x, im_x;
  logic signed [2*DATA_W-1:0] sq_re, sq_im;
  logic                       s1_vld, s1_last;
  logic [ADDR_W-1:0]          s1_addr;
  logic [PWR_W-1:0]           pwr_s1;

  assign src.source_ready = (state != DONE);
  assign acc     = src.source_valid & src.source_ready;
  assign src_err = (src.source_error != 2'b00);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bad_nxt   = bad;
    bad_now   = 1'b0;
    err_set   = 3'b000;
    beat      = 1'b0;
    bin       = cnt;
    last_good = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc && src.source_sop) begin
          beat = 1'b1;
          bin  = '0;
        end
      end
      CAPTURE: begin
        if (acc) begin
          beat = 1'b1;
          if (src.source_sop) begin
            bin        = '0;
            err_set[0] = 1'b1;
          end
        end
      end
      DONE: begin
        if (frame_ack && frame_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A sop beat opens a fresh frame, so earlier bad beats no longer count.
    if (beat) begin
      bad_now = (src.source_sop ? 1'b0 : bad) | src_err;
      if (src_err)
        err_set[2] = 1'b1;
      cnt_nxt   = bin + ADDR_W'(1);
      bad_nxt   = bad_now;
      state_nxt = CAPTURE;
      if (src.source_eop) begin
        state_nxt = IDLE;
        if (bin != LAST) begin
          err_set[0] = 1'b1;
        end else if (!bad_now) begin
          state_nxt = DONE;
          last_good = 1'b1;
        end
      end else if (bin == LAST) begin
        err_set[1] = 1'b1;
        state_nxt  = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      bad   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bad   <= bad_nxt;
    end
  end

  assign re_x   = (2*DATA_W)'(src.source_real);
  assign im_x   = (2*DATA_W)'(src.source_imag);
  assign pwr_s1 = PWR_W'($unsigned(sq_re))
                + PWR_W'($unsigned(sq_im));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      s1_addr    <= '0;
      sq_re      <= '0;
      sq_im      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_exp  <= '0;
      err_flags  <= '0;
    end else begin
      s1_vld  <= beat;
      s1_last <= last_good;
      s1_addr <= bin;
      if (beat) begin
        sq_re <= re_x * re_x;
        sq_im <= im_x * im_x;
      end
      wr_en   <= s1_vld;
      wr_addr <= s1_addr;
      wr_data <= pwr_s1;
      if (beat && src.source_sop)
        frame_exp <= src.source_exp;
      err_flags <= (err_flags & ~{3{err_clr}}) | err_set;
      // Rise together with the final bin's write, never ahead of it.
      if (s1_vld && s1_last)
        frame_done <= 1'b1;
      else if (state == DONE && frame_ack)
        frame_done <= 1'b0;
    end
  end

`ifdef PEAK_DETECT_EN
  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(FFT_PTS / 2);

  logic              s1_sop, in_rng;
  logic [PWR_W-1:0]  run_pwr;
  logic [ADDR_W-1:0] run_bin;

  assign in_rng = (s1_addr != '0) && (s1_addr < HALF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_sop   <= 1'b0;
      run_pwr  <= '0;
      run_bin  <= '0;
      peak_pwr <= '0;
      peak_bin <= '0;
    end else begin
      s1_sop <= beat & src.source_sop;
      // Strict compare keeps the lower bin on ties.
      if (s1_vld && s1_sop) begin
        run_pwr <= '0;
        run_bin <= '0;
      end else if (s1_vld && in_rng && pwr_s1 > run_pwr) begin
        run_pwr <= pwr_s1;
        run_bin <= s1_addr;
      end
      if (s1_vld && s1_last) begin
        peak_pwr <= run_pwr;
        peak_bin <= run_bin;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_source_capture.sv
// Scoreboard bench for fft_source_capture with a beat-level reference model.
// Driver pushes expected writes; a negedge monitor pops and compares.
module tb_fft_source_capture;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int PW = 33;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_ack = 1'b0;
  logic          err_clr = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          frame_done;
  logic [5:0]    frame_exp;
  logic [2:0]    err_flags;
`ifdef PEAK_DETECT_EN
  logic [PW-1:0] peak_pwr;
  logic [AW-1:0] peak_bin;
`endif

  fft_source_capture_if #(.DATA_W(DW)) src ();

  fft_source_capture #(
    .FFT_PTS(N), .DATA_W(DW), .ADDR_W(AW), .PWR_W(PW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .src(src.slave),
    .frame_ack(frame_ack),
    .err_clr(err_clr),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .frame_exp(frame_exp),
    .err_flags(err_flags)
`ifdef PEAK_DETECT_EN
    ,
    .peak_pwr(peak_pwr),
    .peak_bin(peak_bin)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int     addr;
    longint pwr;
    bit     last;
  } wr_t;

  wr_t    q[$];
  int     tests = 0;
  int     fails = 0;
  int     done_rises = 0;
  int     exp_dones = 0;
  bit     done_q = 1'b0;
  bit     gaps = 1'b0;

  // reference model state
  bit     m_in = 1'b0;
  int     m_bin = 0;
  bit     m_bad = 1'b0;
  bit     m_pending = 1'b0;
  int     m_exp = 0;
  int     exp_err = 0;
  longint mp_pwr = 0;
  int     mp_bin = 0;
  longint e_pk_pwr = 0;
  int     e_pk_bin = 0;

  function automatic void check(input string nm,
                                input longint act,
                                input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        if (q.size() == 0) begin
          check("unexpected_write", longint'(wr_addr), -1);
        end else begin
          wr_t e;
          e = q.pop_front();
          check("wr_addr", longint'(wr_addr), longint'(e.addr));
          check("wr_data", longint'(wr_data), e.pwr);
          check("done_with_write", longint'(frame_done),
                longint'(e.last));
        end
      end
      if (frame_done && !done_q)
        done_rises++;
    end
    done_q = frame_done;
  end

  // Spec rules applied to one accepted beat.
  task automatic model(input bit sop, input bit eop, input bit [1:0] er,
                       input int re, input int im, input int ex);
    wr_t    w;
    longint p;
    if (!m_in && !sop) return;
    if (sop) begin
      if (m_in) exp_err |= 1;
      m_bin  = 0;
      m_bad  = 1'b0;
      m_exp  = ex;
      mp_pwr = 0;
      mp_bin = 0;
    end
    if (er != 2'b00) begin
      m_bad = 1'b1;
      exp_err |= 4;
    end
    p = longint'(re) * re + longint'(im) * im;
    if (m_bin >= 1 && m_bin < N / 2 && p > mp_pwr) begin
      mp_pwr = p;
      mp_bin = m_bin;
    end
    w.addr = m_bin;
    w.pwr  = p;
    w.last = 1'b0;
    if (eop) begin
      if (m_bin != N - 1) exp_err |= 1;
      else if (!m_bad) w.last = 1'b1;
      m_in = 1'b0;
    end else if (m_bin == N - 1) begin
      exp_err |= 2;
      m_in = 1'b0;
    end else begin
      m_in = 1'b1;
    end
    if (w.last) begin
      m_pending = 1'b1;
      exp_dones++;
      e_pk_pwr = mp_pwr;
      e_pk_bin = mp_bin;
    end
    q.push_back(w);
    m_bin++;
  endtask

  task automatic beat(input bit sop, input bit eop, input bit [1:0] er,
                      input int re, input int im, input int ex);
    int t = 0;
    int g = gaps ? int'($urandom_range(2, 0)) : 0;
    repeat (g) @(negedge clk);
    src.source_valid = 1'b1;
    src.source_sop   = sop;
    src.source_eop   = eop;
    src.source_error = er;
    src.source_real  = DW'(re);
    src.source_imag  = DW'(im);
    src.source_exp   = 6'(ex);
    while (!src.source_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!src.source_ready) check("ready_timeout", 0, 1);
    else model(sop, eop, er, re, im, ex);
    @(negedge clk);
    src.source_valid = 1'b0;
  endtask

  task automatic finish_done();
    int t = 0;
    while (!frame_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("frame_done_seen", longint'(frame_done), 1);
    check("ready_in_done", longint'(src.source_ready), 0);
    check("frame_exp", longint'(frame_exp), longint'(m_exp));
`ifdef PEAK_DETECT_EN
    check("peak_pwr", longint'(peak_pwr), e_pk_pwr);
    check("peak_bin", longint'(peak_bin), longint'(e_pk_bin));
`endif
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    m_pending = 1'b0;
    check("ready_after_ack", longint'(src.source_ready), 1);
    check("done_after_ack", longint'(frame_done), 0);
  endtask

  task automatic run_frame(input int nb, input int eop_at, input int err_at,
                           input int sop2_at, input int mode);
    int ex = int'($urandom_range(63, 0));
    for (int i = 0; i < nb; i++) begin
      int re;
      int im;
      logic signed [DW-1:0] r;
      unique case (mode)
        1: begin re = i; im = 0; end
        2: begin re = -32768; im = -32768; end
        3: begin re = (i == 2 || i == 3) ? 10 : 1; im = 0; end
        default: begin
          r  = DW'($urandom);
          re = int'(r);
          r  = DW'($urandom);
          im = int'(r);
        end
      endcase
      beat(i == 0 || i == sop2_at, i == eop_at,
           (i == err_at) ? 2'b01 : 2'b00, re, im, ex);
    end
    if (m_pending) finish_done();
  endtask

  task automatic chk_err(input string nm);
    repeat (3) @(negedge clk);
    check(nm, longint'(err_flags), longint'(exp_err));
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 0;
    check("err_after_clr", longint'(err_flags), 0);
  endtask

  task automatic chk_reset_state();
    check("rst_ready", longint'(src.source_ready), 1);
    check("rst_wr_en", longint'(wr_en), 0);
    check("rst_done", longint'(frame_done), 0);
    check("rst_exp", longint'(frame_exp), 0);
    check("rst_err", longint'(err_flags), 0);
`ifdef PEAK_DETECT_EN
    check("rst_peak_pwr", longint'(peak_pwr), 0);
    check("rst_peak_bin", longint'(peak_bin), 0);
`endif
  endtask

  initial begin
    src.source_valid = 1'b0;
    src.source_sop   = 1'b0;
    src.source_eop   = 1'b0;
    src.source_error = 2'b00;
    src.source_real  = '0;
    src.source_imag  = '0;
    src.source_exp   = '0;
    repeat (3) @(negedge clk);
    chk_reset_state();
    reset_n = 1'b1;
    @(negedge clk);

    run_frame(N, N - 1, -1, -1, 1);
    gaps = 1'b1;
    repeat (3) run_frame(N, N - 1, -1, -1, 0);
    run_frame(N, N - 1, -1, -1, 3);

    run_frame(6, 5, -1, -1, 0);
    chk_err("err_early_eop");
    clr_err();
    run_frame(N, N - 1, -1, -1, 0);

    run_frame(N, N - 1, 3, -1, 0);
    chk_err("err_source_error");
    clr_err();

    run_frame(N, -1, -1, -1, 0);
    beat(1'b0, 1'b0, 2'b00, 5, 5, 0);
    chk_err("err_missing_eop");
    clr_err();

    run_frame(11, 10, -1, 3, 0);
    chk_err("err_mid_sop");
    clr_err();

    run_frame(N, N - 1, -1, -1, 2);

    gaps = 1'b0;
    for (int i = 0; i < 3; i++)
      beat(i == 0, 1'b0, 2'b00, 100 + i, 7, 9);
    #2;
    reset_n = 1'b0;
    q.delete();
    m_in = 1'b0;
    m_pending = 1'b0;
    exp_err = 0;
    m_exp = 0;
    #1;
    check("wr_en_in_reset", longint'(wr_en), 0);
    @(negedge clk);
    chk_reset_state();
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    check("wr_en_after_reset", longint'(wr_en), 0);
    run_frame(N, N - 1, -1, -1, 0);

    repeat (6) @(negedge clk);
    check("queue_drained", longint'(q.size()), 0);
    check("done_count", longint'(done_rises), longint'(exp_dones));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
